// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// load_store_unit : byte-lane placing load/store unit with req/gnt/rvalid port
// Revision 1.0
// ============================================================================
module load_store_unit #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            Funct3,
  input  logic [31:0]           addr,
  input  logic [DATA_W-1:0]     wd,
  output logic [DATA_W-1:0]     rd,
  output logic                  stall,
  output logic                  misaligned,
  output logic                  illegal,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT_R = 2'd2, DONE = 2'd3} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              f3_q, f3_d;
  logic [1:0]              off_q, off_d;
  logic [DATA_W-1:0]       rd_q, rd_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [DM_ADDRESS-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]             mem_wdata_q, mem_wdata_d;
  logic [3:0]              mem_be_q, mem_be_d;
  logic                    misaligned_q, misaligned_d;
  logic                    illegal_q, illegal_d;

  logic                    req_any;
  logic                    bad_f3;
  logic                    bad_align;
  logic                    start;
  logic [31:0]             st_wdata;
  logic [3:0]              st_be;
  logic [31:0]             lane;
  logic                    unused_addr_hi;

  assign unused_addr_hi = ^addr[31:DM_ADDRESS];
  assign req_any        = MemRead | MemWrite;

  // Request decode: legality, alignment and store lane placement
  always_comb begin
    bad_f3    = 1'b0;
    bad_align = 1'b0;
    st_wdata  = wd[31:0];
    st_be     = 4'b1111;
    if (MemRead) bad_f3 = (Funct3 == 3'b011) || (Funct3[2:1] == 2'b11);
    else         bad_f3 = (Funct3 >= 3'b011);
    case (Funct3[1:0])
      2'b01:   bad_align = addr[0];
      2'b10:   bad_align = (addr[1:0] != 2'b00);
      default: bad_align = 1'b0;
    endcase
    case (Funct3[1:0])
      2'b00: begin
        st_wdata = {4{wd[7:0]}};
        st_be    = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        st_wdata = {2{wd[15:0]}};
        st_be    = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = wd[31:0];
        st_be    = 4'b1111;
      end
    endcase
  end

  assign start = (state_q == IDLE) && req_any && !bad_f3 && !bad_align;
  assign stall = rst_n & (start | (state_q == REQ) | (state_q == WAIT_R));
  assign lane  = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    state_d      = state_q;
    f3_d         = f3_q;
    off_d        = off_q;
    rd_d         = rd_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    misaligned_d = 1'b0;
    illegal_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          if (bad_f3) begin
            illegal_d = 1'b1;
          end else if (bad_align) begin
            misaligned_d = 1'b1;
          end else begin
            state_d     = REQ;
            f3_d        = Funct3;
            off_d       = addr[1:0];
            mem_req_d   = 1'b1;
            mem_we_d    = !MemRead;
            mem_addr_d  = {addr[DM_ADDRESS-1:2], 2'b00};
            mem_wdata_d = MemRead ? 32'h0 : st_wdata;
            mem_be_d    = MemRead ? 4'b1111 : st_be;
          end
        end
      end
      REQ: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = mem_we_q ? DONE : WAIT_R;
        end
      end
      WAIT_R: begin
        if (mem_rvalid) begin
          case (f3_q)
            3'b000:  rd_d = {{24{lane[7]}}, lane[7:0]};
            3'b100:  rd_d = {24'h0, lane[7:0]};
            3'b001:  rd_d = {{16{lane[15]}}, lane[15:0]};
            3'b101:  rd_d = {16'h0, lane[15:0]};
            default: rd_d = mem_rdata;
          endcase
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      f3_q         <= 3'b000;
      off_q        <= 2'b00;
      rd_q         <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'h0;
      mem_be_q     <= 4'b0000;
      misaligned_q <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      f3_q         <= f3_d;
      off_q        <= off_d;
      rd_q         <= rd_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      misaligned_q <= misaligned_d;
      illegal_q    <= illegal_d;
    end
  end

  assign rd         = rd_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_be     = mem_be_q;
  assign misaligned = misaligned_q;
  assign illegal    = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// tb_load_store_unit : directed self-checking bench for load_store_unit
// Revision 1.0
// ============================================================================
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] addr, wd, rd;
  logic        stall, misaligned, illegal;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int total = 0;
  int bad   = 0;

  // memory responder knobs
  int          gnt_delay = 0;
  int          rv_delay  = 0;
  bit          stray_en  = 0;
  logic [31:0] rdata_cfg = 32'h0;
  bit          pend;
  int          rcnt, qcnt;

  // per-operation observations
  int          n_stall, n_req;
  bit          unstable;
  logic [8:0]  c_addr;
  logic        c_we;
  logic [3:0]  c_be;
  logic [31:0] c_wdata;

  load_store_unit #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
    .Funct3(Funct3), .addr(addr), .wd(wd), .rd(rd), .stall(stall),
    .misaligned(misaligned), .illegal(illegal), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Memory model: grant after gnt_delay wait states, rvalid rv_delay cycles after grant
  initial begin
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    pend = 1'b0; rcnt = 0; qcnt = 0;
    forever begin
      @(negedge clk);
      mem_rdata = rdata_cfg;
      if (mem_rvalid) begin
        mem_rvalid = 1'b0;
        pend       = 1'b0;
      end else if (pend) begin
        rcnt++;
        if (rcnt > rv_delay) mem_rvalid = 1'b1;
      end
      if (mem_req) begin
        qcnt++;
        mem_gnt = (qcnt > gnt_delay);
      end else begin
        qcnt    = 0;
        mem_gnt = 1'b0;
      end
      if (mem_req && mem_gnt && !mem_we) begin
        pend = 1'b1;
        rcnt = 0;
      end
      if (stray_en && mem_req && !mem_gnt) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
      end
    end
  end

  // Issue one valid op from IDLE; returns at the negedge of the DONE cycle
  task automatic do_op(input logic r, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    bit done;
    done = 1'b0;
    MemRead = r; MemWrite = w; Funct3 = f3; addr = a; wd = d;
    n_stall = 0; n_req = 0; unstable = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (mem_req) begin
        if (n_req == 0) begin
          c_addr = mem_addr; c_we = mem_we; c_be = mem_be; c_wdata = mem_wdata;
        end else if ({mem_addr, mem_we, mem_be, mem_wdata} !== {c_addr, c_we, c_be, c_wdata}) begin
          unstable = 1'b1;
        end
        n_req++;
      end
      if (stall) n_stall++;
      else       done = 1'b1;
      if (!done) begin
        next();
        MemRead = 1'b0; MemWrite = 1'b0;
      end
    end
    MemRead = 1'b0; MemWrite = 1'b0;
    if (!done) check("op_timeout", 32'd0, 32'd1);
  endtask

  // Rejected request: count flag pulses, requests and stall over a few cycles
  task automatic bad_op(input string tag, input logic r, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input int exp_mis, input int exp_ill);
    int pm, pi, rq, st;
    pm = 0; pi = 0; rq = 0; st = 0;
    MemRead = r; MemWrite = w; Funct3 = f3; addr = a;
    @(negedge clk);
    st += int'(stall);
    next();
    MemRead = 1'b0; MemWrite = 1'b0;
    repeat (3) begin
      @(negedge clk);
      pm += int'(misaligned);
      pi += int'(illegal);
      rq += int'(mem_req);
      st += int'(stall);
    end
    check({tag, "_mis"},   pm, exp_mis);
    check({tag, "_ill"},   pi, exp_ill);
    check({tag, "_req"},   rq, 0);
    check({tag, "_stall"}, st, 0);
    next();
  endtask

  initial begin
    MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'b000; addr = 32'h0; wd = 32'h0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_rd",    rd, 32'h0);
    check("rst_stall", stall, 0);
    check("rst_req",   mem_req, 0);
    check("rst_we",    mem_we, 0);
    check("rst_be",    mem_be, 0);
    check("rst_addr",  mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_flags", {misaligned, illegal}, 0);
    #9 rst_n = 1'b1;
    next();

    // LB at 0x103, no wait states
    rdata_cfg = 32'h80FF_1234; gnt_delay = 0; rv_delay = 0;
    do_op(1'b1, 1'b0, 3'b000, 32'h103, 32'h0);
    check("lb_addr",  c_addr, 9'h100);
    check("lb_we",    c_we, 0);
    check("lb_be",    c_be, 4'hF);
    check("lb_stall", n_stall, 3);
    check("lb_rd",    rd, 32'hFFFF_FF80);
    next();

    // SH at 0x0A with 3 grant wait states
    gnt_delay = 3;
    do_op(1'b0, 1'b1, 3'b001, 32'h0A, 32'h1234_ABCD);
    check("sh_req_cyc", n_req, 4);
    check("sh_stable",  unstable, 0);
    check("sh_addr",    c_addr, 9'h008);
    check("sh_wdata",   c_wdata, 32'hABCD_ABCD);
    check("sh_be",      c_be, 4'b1100);
    check("sh_we",      c_we, 1);
    check("sh_stall",   n_stall, 5);
    check("sh_rd_kept", rd, 32'hFFFF_FF80);
    next();
    gnt_delay = 0;

    // rejected requests
    bad_op("lw_mis", 1'b1, 1'b0, 3'b010, 32'h06, 1, 0);
    bad_op("ld_011", 1'b1, 1'b0, 3'b011, 32'h00, 0, 1);
    bad_op("st_011", 1'b0, 1'b1, 3'b011, 32'h00, 0, 1);
    bad_op("sw_mis", 1'b0, 1'b1, 3'b010, 32'h02, 1, 0);

    // LHU at 0x02: grant after 2 waits with stray rvalid, response 5 cycles late
    rdata_cfg = 32'hF00D_1234; gnt_delay = 2; rv_delay = 5; stray_en = 1'b1;
    do_op(1'b1, 1'b0, 3'b101, 32'h02, 32'h0);
    check("lhu_rd",    rd, 32'h0000_F00D);
    check("lhu_stall", n_stall, 10);
    next();
    gnt_delay = 0; rv_delay = 0; stray_en = 1'b0;

    do_op(1'b1, 1'b0, 3'b001, 32'h02, 32'h0);
    check("lh_rd", rd, 32'hFFFF_F00D);
    next();

    // SB at lane 1
    do_op(1'b0, 1'b1, 3'b000, 32'h41, 32'h0000_00A5);
    check("sb_wdata", c_wdata, 32'hA5A5_A5A5);
    check("sb_be",    c_be, 4'b0010);
    check("sb_stall", n_stall, 2);
    next();

    // MemRead and MemWrite together: load wins
    rdata_cfg = 32'hCAFE_F00D;
    do_op(1'b1, 1'b1, 3'b010, 32'h10, 32'h1111_1111);
    check("both_we",   c_we, 0);
    check("both_addr", c_addr, 9'h010);
    check("both_rd",   rd, 32'hCAFE_F00D);
    next();

    // back-to-back SW then LW
    do_op(1'b0, 1'b1, 3'b010, 32'h20, 32'h1122_3344);
    check("sw_wdata", c_wdata, 32'h1122_3344);
    check("sw_be",    c_be, 4'hF);
    check("sw_stall", n_stall, 2);
    check("sw_rd",    rd, 32'hCAFE_F00D);
    next();
    rdata_cfg = 32'h5566_7788;
    do_op(1'b1, 1'b0, 3'b010, 32'h24, 32'h0);
    check("lw_rd",    rd, 32'h5566_7788);
    check("lw_stall", n_stall, 3);
    next();

    // reset asserted while waiting for the read response
    rdata_cfg = 32'h9988_7766; rv_delay = 10;
    MemRead = 1'b1; Funct3 = 3'b010; addr = 32'h30;
    next();
    MemRead = 1'b0;
    next();
    next();
    check("wr_stall_pre", stall, 1);
    rst_n = 1'b0;
    #1;
    check("ar_stall", stall, 0);
    check("ar_rd",    rd, 32'h0);
    check("ar_be",    mem_be, 4'h0);
    check("ar_addr",  mem_addr, 9'h0);
    check("ar_req",   mem_req, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (16) @(negedge clk);
    check("ar_late_rd",    rd, 32'h0);
    check("ar_late_stall", stall, 0);
    rv_delay = 0;
    next();

    // unit resumes after reset
    rdata_cfg = 32'h80FF_1234;
    do_op(1'b1, 1'b0, 3'b100, 32'h03, 32'h0);
    check("lbu_rd", rd, 32'h0000_0080);
    next();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
